// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU front end.
//   ALU_DW     : datapath width the operand bundle is built for
//   ALUC_*     : ALU control codes carried through the operand stage
//   operand_t  : bundle handed to the ALU (a, b, aluc, rd, wreg)
//   ext_imm()  : 16-bit immediate extension helper
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_DW = 32;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_HAM = 4'b1011;

  typedef struct packed {
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic [3:0]        aluc;
    logic [4:0]        rd;
    logic              wreg;
  } operand_t;

  // Sign- or zero-extend a 16-bit immediate to the datapath width.
  function automatic logic [ALU_DW-1:0] ext_imm(input logic [15:0] imm, input logic sext);
    logic fill;
    fill = sext & imm[15];
    return {{(ALU_DW-16){fill}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_if
// Handshake and data bus of the ALU operand stage.
//   in_*        : decoded operation from the decoder, valid/ready handshake
//   out_*       : operand bundle towards the ALU, valid/ready handshake
//   stall_cnt   : saturating count of cycles the consumer stalled us
//   fwd_*/in_*_num : forwarding inputs, present only with ALU_FWD_EN defined
// Modports:
//   slave  : the operand stage itself
//   master : the environment (decoder + ALU side)
// -----------------------------------------------------------------------------
interface alu_operand_stage_if #(
  parameter int unsigned DW     = 32,
  parameter int unsigned SCNT_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_aluc;
  logic [DW-1:0]     in_rs_val;
  logic [DW-1:0]     in_rt_val;
  logic [15:0]       in_imm;
  logic [4:0]        in_shamt;
  logic              in_aluimm;
  logic              in_sext;
  logic              in_shift;
  logic [4:0]        in_rd;
  logic              in_wreg;

  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_a;
  logic [DW-1:0]     out_b;
  logic [3:0]        out_aluc;
  logic [4:0]        out_rd;
  logic              out_wreg;

  logic [SCNT_W-1:0] stall_cnt;

`ifdef ALU_FWD_EN
  logic [4:0]        in_rs_num;
  logic [4:0]        in_rt_num;
  logic              fwd_wen;
  logic [4:0]        fwd_rd;
  logic [DW-1:0]     fwd_data;
`endif

  modport slave (
    input  in_valid, in_aluc, in_rs_val, in_rt_val, in_imm, in_shamt,
    input  in_aluimm, in_sext, in_shift, in_rd, in_wreg,
    output in_ready,
    input  out_ready,
    output out_valid, out_a, out_b, out_aluc, out_rd, out_wreg,
`ifdef ALU_FWD_EN
    input  in_rs_num, in_rt_num, fwd_wen, fwd_rd, fwd_data,
`endif
    output stall_cnt
  );

  modport master (
    output in_valid, in_aluc, in_rs_val, in_rt_val, in_imm, in_shamt,
    output in_aluimm, in_sext, in_shift, in_rd, in_wreg,
    input  in_ready,
    output out_ready,
    input  out_valid, out_a, out_b, out_aluc, out_rd, out_wreg,
`ifdef ALU_FWD_EN
    output in_rs_num, in_rt_num, fwd_wen, fwd_rd, fwd_data,
`endif
    input  stall_cnt
  );

endinterface

// File: rtl/skid_buf2.sv
// -----------------------------------------------------------------------------
// skid_buf2
// Generic 2-entry valid/ready skid buffer. An output register (OR) drives the
// consumer; a skid register (SK) catches one extra entry when the consumer
// stalls. o_in_ready is registered and depends only on the skid occupancy,
// never combinationally on i_out_ready. Strict FIFO order.
//   clock, resetn  : clock and asynchronous active-low reset
//   i_in_valid     : producer has data
//   o_in_ready     : buffer can take data this cycle
//   i_in_data      : producer data
//   o_out_valid    : o_out_data is valid
//   i_out_ready    : consumer takes data this cycle
//   o_out_data     : buffered data (contents of OR)
// -----------------------------------------------------------------------------
module skid_buf2 #(
  parameter type T = logic [7:0]
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_in_valid,
  output logic o_in_ready,
  input  T     i_in_data,
  output logic o_out_valid,
  input  logic i_out_ready,
  output T     o_out_data
);

  logic r_or_v;
  logic r_sk_v;
  logic r_in_ready;
  T     r_or;
  T     r_sk;

  logic w_accept;
  logic w_fire;
  logic w_or_v_d;
  logic w_sk_v_d;
  logic w_or_load_sk;
  logic w_or_load_in;
  logic w_sk_load;

  assign w_accept = i_in_valid & r_in_ready;
  assign w_fire   = r_or_v & i_out_ready;

  always_comb begin
    w_or_v_d     = r_or_v;
    w_sk_v_d     = r_sk_v;
    w_or_load_sk = 1'b0;
    w_or_load_in = 1'b0;
    w_sk_load    = 1'b0;
    if (!r_or_v || w_fire) begin
      // OR is free this edge: the skid entry is older, so it goes first.
      if (r_sk_v) begin
        w_or_load_sk = 1'b1;
        w_or_v_d     = 1'b1;
        w_sk_v_d     = 1'b0;
      end else if (w_accept) begin
        w_or_load_in = 1'b1;
        w_or_v_d     = 1'b1;
      end else begin
        w_or_v_d     = 1'b0;
      end
    end else if (w_accept) begin
      // OR is stuck: park the new entry in SK.
      w_sk_load = 1'b1;
      w_sk_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_or_v     <= 1'b0;
      r_sk_v     <= 1'b0;
      r_in_ready <= 1'b0;
      r_or       <= '0;
      r_sk       <= '0;
    end else begin
      r_or_v     <= w_or_v_d;
      r_sk_v     <= w_sk_v_d;
      // Registered copy of ~sk_v; low during reset, high from the first edge after.
      r_in_ready <= ~w_sk_v_d;
      if (w_or_load_sk) begin
        r_or <= r_sk;
      end else if (w_or_load_in) begin
        r_or <= i_in_data;
      end
      if (w_sk_load) begin
        r_sk <= i_in_data;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_or_v;
  assign o_out_data  = r_or;

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
// Operand stage in front of the single-cycle ALU. Optionally forwards a
// late register write onto rs/rt, forms operands a and b from register values,
// shift amount and immediate, and hands the bundle through a 2-entry skid
// buffer. Counts stall cycles (out_valid & ~out_ready), saturating.
//   clock, resetn : clock and asynchronous active-low reset
//   bus (slave)   : in_* decoded op + handshake, out_* operand bundle +
//                   handshake, stall_cnt
// Build option:
//   ALU_FWD_EN    : adds in_rs_num/in_rt_num/fwd_wen/fwd_rd/fwd_data to the
//                   bus and enables forwarding at input capture.
// DW must match alu_pkg::ALU_DW, the width of the operand bundle.
// -----------------------------------------------------------------------------
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW     = ALU_DW,
  parameter int unsigned SCNT_W = 16
) (
  input  logic               clock,
  input  logic               resetn,
  alu_operand_stage_if.slave bus
);

  logic [DW-1:0]     w_rs_val;
  logic [DW-1:0]     w_rt_val;
  logic [DW-1:0]     w_ext;
  operand_t          w_in_op;
  operand_t          w_out_op;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [SCNT_W-1:0] r_stall_cnt;

  // Forwarding only touches the incoming operation; held entries are final.
`ifdef ALU_FWD_EN
  logic w_fwd_rs;
  logic w_fwd_rt;

  assign w_fwd_rs = bus.fwd_wen && (bus.fwd_rd != 5'd0) && (bus.fwd_rd == bus.in_rs_num);
  assign w_fwd_rt = bus.fwd_wen && (bus.fwd_rd != 5'd0) && (bus.fwd_rd == bus.in_rt_num);
  assign w_rs_val = w_fwd_rs ? bus.fwd_data : bus.in_rs_val;
  assign w_rt_val = w_fwd_rt ? bus.fwd_data : bus.in_rt_val;
`else
  assign w_rs_val = bus.in_rs_val;
  assign w_rt_val = bus.in_rt_val;
`endif

  assign w_ext = ext_imm(bus.in_imm, bus.in_sext);

  always_comb begin
    w_in_op      = '0;
    w_in_op.a    = bus.in_shift ? {{(DW-5){1'b0}}, bus.in_shamt} : w_rs_val;
    w_in_op.b    = bus.in_aluimm ? w_ext : w_rt_val;
    w_in_op.aluc = bus.in_aluc;
    w_in_op.rd   = bus.in_rd;
    w_in_op.wreg = bus.in_wreg;
  end

  skid_buf2 #(
    .T(operand_t)
  ) u_skid (
    .clock      (clock),
    .resetn     (resetn),
    .i_in_valid (bus.in_valid),
    .o_in_ready (w_in_ready),
    .i_in_data  (w_in_op),
    .o_out_valid(w_out_valid),
    .i_out_ready(bus.out_ready),
    .o_out_data (w_out_op)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != {SCNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_a     = w_out_op.a;
  assign bus.out_b     = w_out_op.b;
  assign bus.out_aluc  = w_out_op.aluc;
  assign bus.out_rd    = w_out_op.rd;
  assign bus.out_wreg  = w_out_op.wreg;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
// Self-checking bench for alu_operand_stage. The reference model is a FIFO of
// capacity two holding operand bundles computed arithmetically from the
// decoded fields, plus a saturating stall counter.
// Build option: ALU_FWD_EN enables the forwarding scenario.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;
  import alu_pkg::*;

  localparam int unsigned DW     = 32;
  localparam int unsigned SCNT_W = 16;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        aluimm;
    logic        sext;
    logic        shift;
    logic [3:0]  aluc;
    logic [4:0]  rd;
    logic        wreg;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic        fwd_wen;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
  } op_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  alu_operand_stage_if #(.DW(DW), .SCNT_W(SCNT_W)) bus ();

  alu_operand_stage #(
    .DW    (DW),
    .SCNT_W(SCNT_W)
  ) u_dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  operand_t    mq[$];
  logic [15:0] m_stall = '0;
  bit          m_fresh = 1'b1;

  function automatic operand_t model(input op_t o);
    operand_t    r;
    logic [31:0] rs;
    logic [31:0] rt;
    rs = o.rs_val;
    rt = o.rt_val;
`ifdef ALU_FWD_EN
    if (o.fwd_wen && o.fwd_rd != 5'd0 && o.fwd_rd == o.rs_num) rs = o.fwd_data;
    if (o.fwd_wen && o.fwd_rd != 5'd0 && o.fwd_rd == o.rt_num) rt = o.fwd_data;
`endif
    r.a = o.shift ? 32'(o.shamt) : rs;
    if (!o.aluimm)                        r.b = rt;
    else if (o.sext && o.imm >= 16'h8000) r.b = 32'(o.imm) + 32'hFFFF_0000;
    else                                  r.b = 32'(o.imm);
    r.aluc = o.aluc;
    r.rd   = o.rd;
    r.wreg = o.wreg;
    return r;
  endfunction

  function automatic op_t idle_op();
    op_t o;
    o = '0;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.rs_val   = $urandom;
    o.rt_val   = $urandom;
    o.imm      = 16'($urandom);
    o.shamt    = 5'($urandom);
    o.aluimm   = 1'($urandom);
    o.sext     = 1'($urandom);
    o.shift    = 1'($urandom);
    o.aluc     = 4'($urandom);
    o.rd       = 5'($urandom);
    o.wreg     = 1'($urandom);
    o.rs_num   = 5'($urandom_range(0, 3));
    o.rt_num   = 5'($urandom_range(0, 3));
    o.fwd_wen  = 1'($urandom);
    o.fwd_rd   = 5'($urandom_range(0, 3));
    o.fwd_data = $urandom;
    return o;
  endfunction

  task automatic drive(input op_t o, input logic v);
    bus.in_valid  = v;
    bus.in_aluc   = o.aluc;
    bus.in_rs_val = o.rs_val;
    bus.in_rt_val = o.rt_val;
    bus.in_imm    = o.imm;
    bus.in_shamt  = o.shamt;
    bus.in_aluimm = o.aluimm;
    bus.in_sext   = o.sext;
    bus.in_shift  = o.shift;
    bus.in_rd     = o.rd;
    bus.in_wreg   = o.wreg;
`ifdef ALU_FWD_EN
    bus.in_rs_num = o.rs_num;
    bus.in_rt_num = o.rt_num;
    bus.fwd_wen   = o.fwd_wen;
    bus.fwd_rd    = o.fwd_rd;
    bus.fwd_data  = o.fwd_data;
`endif
  endtask

  // Advance the model by one clock edge given the inputs applied this cycle.
  task automatic model_step(input logic v, input logic rdy, input op_t o);
    bit mv;
    bit mir;
    mv  = mq.size() > 0;
    mir = (mq.size() < 2) && !m_fresh;
    if (mv && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (mv && rdy) void'(mq.pop_front());
    if (v && mir) mq.push_back(model(o));
    m_fresh = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic operand_t observed();
    operand_t r;
    r.a    = bus.out_a;
    r.b    = bus.out_b;
    r.aluc = bus.out_aluc;
    r.rd   = bus.out_rd;
    r.wreg = bus.out_wreg;
    return r;
  endfunction

  task automatic test_reset();
    operand_t z;
    z = '0;
    drive(rand_op(), 1'b1);
    bus.out_ready = 1'b0;
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    n_checks++;
    if (observed() !== z) begin
      n_errors++; $display("FAIL reset_out_bundle: got %h want 0", observed());
    end
    n_checks++;
    if (bus.stall_cnt !== 16'd0) begin
      n_errors++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_held_out_valid: got %b want 0", bus.out_valid);
    end
    @(negedge clock);
    resetn = 1'b1;
    mq.delete();
    m_stall = '0;
    m_fresh = 1'b1;
    drive(idle_op(), 1'b0);
    bus.out_ready = 1'b1;
    model_step(1'b0, 1'b1, idle_op());
    tick();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_sext();
    op_t o;
    o = idle_op();
    o.aluimm = 1'b1; o.sext = 1'b1; o.imm = 16'hFFFE; o.rs_val = 32'd5;
    o.aluc = ALUC_ADD; o.rd = 5'd7; o.wreg = 1'b1;
    drive(o, 1'b1);
    bus.out_ready = 1'b1;
    model_step(1'b1, 1'b1, o);
    tick();
    drive(idle_op(), 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_errors++; $display("FAIL sext_out_valid: got %b want 1", bus.out_valid);
    end
    n_checks++;
    if (bus.out_a !== 32'd5 || bus.out_b !== 32'hFFFF_FFFE) begin
      n_errors++; $display("FAIL sext_operands: got a=%h b=%h want a=5 b=fffffffe", bus.out_a, bus.out_b);
    end
    n_checks++;
    if (bus.out_aluc !== 4'b0000 || bus.out_rd !== 5'd7 || bus.out_wreg !== 1'b1) begin
      n_errors++; $display("FAIL sext_ctl: got aluc=%b rd=%0d wreg=%b want 0000 7 1", bus.out_aluc, bus.out_rd, bus.out_wreg);
    end
    model_step(1'b0, 1'b1, idle_op());
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL sext_drained: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_zext_shift();
    op_t o;
    o = idle_op();
    o.shift = 1'b1; o.shamt = 5'd4; o.aluimm = 1'b1; o.sext = 1'b0; o.imm = 16'h8001;
    o.rs_val = 32'hFFFF_FFFF; o.aluc = ALUC_SLL;
    drive(o, 1'b1);
    bus.out_ready = 1'b1;
    model_step(1'b1, 1'b1, o);
    tick();
    drive(idle_op(), 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 32'd4 || bus.out_b !== 32'h0000_8001) begin
      n_errors++; $display("FAIL zext_shift: got v=%b a=%h b=%h want v=1 a=4 b=00008001", bus.out_valid, bus.out_a, bus.out_b);
    end
    model_step(1'b0, 1'b1, idle_op());
    tick();
  endtask

  task automatic test_backpressure();
    op_t         oa, ob, oc;
    operand_t    ea, eb;
    logic [15:0] s0;
    oa = rand_op(); ob = rand_op(); oc = rand_op();
    ea = model(oa); eb = model(ob);
    s0 = m_stall;
    bus.out_ready = 1'b0;
    drive(oa, 1'b1); model_step(1'b1, 1'b0, oa); tick();
    drive(ob, 1'b1);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_ready_for_b: got %b want 1", bus.in_ready);
    end
    model_step(1'b1, 1'b0, ob); tick();
    drive(oc, 1'b1);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_errors++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready);
      end
      n_checks++;
      if (bus.out_valid !== 1'b1 || observed() !== ea) begin
        n_errors++; $display("FAIL bp_hold_a: got v=%b %h want v=1 %h", bus.out_valid, observed(), ea);
      end
      model_step(1'b1, 1'b0, oc); tick();
    end
    n_checks++;
    if (bus.stall_cnt !== s0 + 16'd3) begin
      n_errors++; $display("FAIL bp_stall_cnt: got %0d want %0d", bus.stall_cnt, s0 + 16'd3);
    end
    drive(idle_op(), 1'b0);
    bus.out_ready = 1'b1;
    n_checks++;
    if (observed() !== ea) begin
      n_errors++; $display("FAIL bp_emit_a: got %h want %h", observed(), ea);
    end
    model_step(1'b0, 1'b1, idle_op()); tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || observed() !== eb) begin
      n_errors++; $display("FAIL bp_emit_b: got v=%b %h want v=1 %h", bus.out_valid, observed(), eb);
    end
    model_step(1'b0, 1'b1, idle_op()); tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL bp_no_dup_or_c: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    op_t         ops[8];
    logic [15:0] s0;
    s0 = m_stall;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ops[i] = rand_op();
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || observed() !== model(ops[i-1])) begin
          n_errors++; $display("FAIL b2b_out_%0d: got v=%b %h want v=1 %h", i - 1, bus.out_valid, observed(), model(ops[i-1]));
        end
      end
      if (i < 8) begin
        drive(ops[i], 1'b1); model_step(1'b1, 1'b1, ops[i]);
      end else begin
        drive(idle_op(), 1'b0); model_step(1'b0, 1'b1, idle_op());
      end
      tick();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== s0) begin
      n_errors++; $display("FAIL b2b_end: got v=%b stall=%0d want v=0 stall=%0d", bus.out_valid, bus.stall_cnt, s0);
    end
  endtask

  task automatic test_random();
    op_t  o;
    logic v;
    logic rdy;
    for (int c = 0; c < 400; c++) begin
      n_checks++;
      if (bus.in_ready !== (mq.size() < 2)) begin
        n_errors++; $display("FAIL rnd_in_ready @%0d: got %b want %b", c, bus.in_ready, mq.size() < 2);
      end
      n_checks++;
      if (bus.out_valid !== (mq.size() > 0)) begin
        n_errors++; $display("FAIL rnd_out_valid @%0d: got %b want %b", c, bus.out_valid, mq.size() > 0);
      end else if (mq.size() > 0) begin
        n_checks++;
        if (observed() !== mq[0]) begin
          n_errors++; $display("FAIL rnd_bundle @%0d: got %h want %h", c, observed(), mq[0]);
        end
      end
      n_checks++;
      if (bus.stall_cnt !== m_stall) begin
        n_errors++; $display("FAIL rnd_stall_cnt @%0d: got %0d want %0d", c, bus.stall_cnt, m_stall);
      end
      o   = rand_op();
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      drive(o, v);
      bus.out_ready = rdy;
      model_step(v, rdy, o);
      tick();
    end
    drive(idle_op(), 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      model_step(1'b0, 1'b1, idle_op());
      tick();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || mq.size() != 0) begin
      n_errors++; $display("FAIL rnd_drain: got v=%b model=%0d want empty", bus.out_valid, mq.size());
    end
  endtask

  task automatic test_async_reset();
    op_t o;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      o = rand_op();
      drive(o, 1'b1); model_step(1'b1, 1'b0, o); tick();
    end
    drive(idle_op(), 1'b0);
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.stall_cnt === 16'd0) begin
      n_errors++; $display("FAIL arst_pre_full: got rdy=%b v=%b stall=%0d want 0 1 nonzero", bus.in_ready, bus.out_valid, bus.stall_cnt);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL arst_immediate: got v=%b stall=%0d rdy=%b want 0 0 0", bus.out_valid, bus.stall_cnt, bus.in_ready);
    end
    n_checks++;
    if (bus.out_a !== 32'd0 || bus.out_b !== 32'd0) begin
      n_errors++; $display("FAIL arst_data: got a=%h b=%h want 0 0", bus.out_a, bus.out_b);
    end
    mq.delete();
    m_stall = '0;
    m_fresh = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    model_step(1'b0, 1'b1, idle_op()); tick();
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_errors++; $display("FAIL arst_release: got rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

`ifdef ALU_FWD_EN
  task automatic test_forward();
    op_t o;
    o = idle_op();
    o.rs_num = 5'd3; o.rt_num = 5'd3; o.rs_val = 32'h1111_1111; o.rt_val = 32'h2222_2222;
    o.fwd_wen = 1'b1; o.fwd_rd = 5'd3; o.fwd_data = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    drive(o, 1'b1); model_step(1'b1, 1'b1, o); tick();
    n_checks++;
    if (bus.out_a !== 32'hDEAD_BEEF || bus.out_b !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL fwd_hit: got a=%h b=%h want deadbeef", bus.out_a, bus.out_b);
    end
    o.fwd_rd = 5'd0;
    drive(o, 1'b1); model_step(1'b1, 1'b1, o); tick();
    n_checks++;
    if (bus.out_a !== 32'h1111_1111 || bus.out_b !== 32'h2222_2222) begin
      n_errors++; $display("FAIL fwd_r0: got a=%h b=%h want 11111111 22222222", bus.out_a, bus.out_b);
    end
    drive(idle_op(), 1'b0); model_step(1'b0, 1'b1, idle_op()); tick();
  endtask
`endif

  initial begin
    bus.out_ready = 1'b0;
    drive(idle_op(), 1'b0);
    test_reset();
    test_sext();
    test_zext_shift();
    test_backpressure();
    test_back_to_back();
`ifdef ALU_FWD_EN
    test_forward();
`endif
    test_random();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
